// File: rtl/extend.sv
// Immediate extender: decodes the immediate field of an instruction word
// (imm_in = instr[31:7]) according to extend_ctrl and registers the result.
// The output changes one clock after the inputs. Reset is synchronous and
// takes priority over the decoded value.
module extend (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] imm_in,
  input  logic [2:0]  extend_ctrl,
  output logic [31:0] imm_out
);

  // Format codes. 101, 110 and 111 are reserved and decode to zero.
  localparam logic [2:0] CTRL_I = 3'b000;
  localparam logic [2:0] CTRL_S = 3'b001;
  localparam logic [2:0] CTRL_B = 3'b010;
  localparam logic [2:0] CTRL_U = 3'b011;
  localparam logic [2:0] CTRL_J = 3'b100;

  // instr[31] is the only sign source for I, S, B and J.
  logic        sign_bit;
  logic [31:0] imm_next;

  assign sign_bit = imm_in[24];

  // Decode the selected format; every code is listed so the result is never X.
  always_comb begin
    imm_next = 32'h0000_0000;
    case (extend_ctrl)
      CTRL_I: imm_next = {{20{sign_bit}}, imm_in[24:13]};
      CTRL_S: imm_next = {{20{sign_bit}}, imm_in[24:18], imm_in[4:0]};
      CTRL_B: imm_next = {{19{sign_bit}}, imm_in[24], imm_in[0],
                          imm_in[23:18], imm_in[4:1], 1'b0};
      CTRL_U: imm_next = {imm_in[24:5], 12'b0};
      CTRL_J: imm_next = {{11{sign_bit}}, imm_in[24], imm_in[12:5],
                          imm_in[13], imm_in[23:14], 1'b0};
      3'b101:  imm_next = 32'h0000_0000;
      3'b110:  imm_next = 32'h0000_0000;
      3'b111:  imm_next = 32'h0000_0000;
      default: imm_next = 32'h0000_0000;
    endcase
  end

  // Output register: reset wins, otherwise load the decoded immediate every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_out <= 32'h0000_0000;
    end else begin
      imm_out <= imm_next;
    end
  end

endmodule

// File: tb/tb_extend.sv
// Bench for the immediate extender: directed vectors, reset and latency
// checks, then randomized traffic checked against an arithmetic model that
// works from the RISC-V instruction field definitions.
module tb_extend;

  logic        clk;
  logic        rst;
  logic [24:0] imm_in;
  logic [2:0]  extend_ctrl;
  logic [31:0] imm_out;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  extend dut (
    .clk         (clk),
    .rst         (rst),
    .imm_in      (imm_in),
    .extend_ctrl (extend_ctrl),
    .imm_out     (imm_out)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: rebuild the instruction word and evaluate the
  // immediate value numerically from its fields.
  function automatic logic [31:0] model(input logic r, input logic [2:0] c,
                                        input logic [24:0] imm);
    logic [31:0] instr;
    longint      v;
    instr = {imm, 7'b0};
    v = 0;
    if (r) return 32'h0;
    case (c)
      3'd0: begin
        v = longint'(instr[31:20]);
        if (instr[31]) v = v - 4096;
      end
      3'd1: begin
        v = longint'(instr[31:25]) * 32 + longint'(instr[11:7]);
        if (instr[31]) v = v - 4096;
      end
      3'd2: begin
        v = longint'(instr[31]) * 4096 + longint'(instr[7]) * 2048
          + longint'(instr[30:25]) * 32 + longint'(instr[11:8]) * 2;
        if (instr[31]) v = v - 8192;
      end
      3'd3: v = longint'(instr[31:12]) * 4096;
      3'd4: begin
        v = longint'(instr[31]) * (1 << 20) + longint'(instr[19:12]) * 4096
          + longint'(instr[20]) * 2048 + longint'(instr[30:21]) * 2;
        if (instr[31]) v = v - (1 << 21);
      end
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (imm_out === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, imm_out, exp);
    end
  endtask

  // Drive one set of inputs at the falling edge, let one rising edge pass,
  // then compare against the expected-queue head.
  task automatic step(input logic r, input logic [2:0] c, input logic [24:0] imm,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    rst = r;
    extend_ctrl = c;
    imm_in = imm;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, exp_q.pop_front());
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] e;
    logic        r;
    logic [2:0]  c;
    logic [24:0] imm;
    total = 0;
    bad = 0;
    rst = 1'b1;
    extend_ctrl = 3'b000;
    imm_in = 25'h1000000;

    // Reset held for two edges with a nonzero-producing input present.
    step(1'b1, 3'b000, 25'h1000000, 32'h0, "reset_edge1");
    step(1'b1, 3'b000, 25'h1000000, 32'h0, "reset_edge2");
    step(1'b0, 3'b000, 25'h1000000, 32'hFFFFF800, "reset_release");

    // I-type.
    step(1'b0, 3'b000, 25'h0002000, 32'h00000001, "i_one");
    step(1'b0, 3'b000, 25'h0FFFFFF, 32'h000007FF, "i_max_pos");
    step(1'b0, 3'b000, 25'h1000000, 32'hFFFFF800, "i_min_neg");

    // S-type and B-type.
    step(1'b0, 3'b001, 25'b1111100_0000001111111_10101, 32'hFFFFFF95, "s_neg");
    step(1'b0, 3'b001, 25'h00000FF, 32'h0000001F, "s_pos");
    step(1'b0, 3'b010, 25'b1_000011_0000001111111_1111_0, 32'hFFFFF07E, "b_neg");
    step(1'b0, 3'b010, 25'b0_000000_0000001111111_1111_1, 32'h0000081E, "b_bit11");

    // U-type and J-type.
    step(1'b0, 3'b011, 25'b11111111111111111111_00000, 32'hFFFFF000, "u_all");
    step(1'b0, 3'b100, 25'b0_1111111111_1_11111111_11111, 32'h000FFFFE, "j_max_pos");
    step(1'b0, 3'b100, 25'b1_0000000000_0_00000000_11111, 32'hFFF00000, "j_min_neg");

    // Reserved codes.
    step(1'b0, 3'b101, 25'h1FFFFFF, 32'h0, "rsv_101");
    step(1'b0, 3'b110, 25'h1FFFFFF, 32'h0, "rsv_110");
    step(1'b0, 3'b111, 25'h1FFFFFF, 32'h0, "rsv_111");

    // Latency: change inputs between edges; output must hold until the edge.
    step(1'b0, 3'b000, 25'h0FFFFFF, 32'h000007FF, "lat_setup");
    held = 32'h000007FF;
    @(negedge clk);
    extend_ctrl = 3'b011;
    imm_in = 25'h1FFFFFF;
    #2;
    check("lat_hold", held);
    @(posedge clk);
    #1;
    check("lat_update", 32'hFFFFF000);

    // Reset asserted between edges is not asynchronous.
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rst_sync_hold", 32'hFFFFF000);
    @(posedge clk);
    #1;
    check("rst_mid_stream", 32'h0);
    step(1'b0, 3'b011, 25'h1FFFFFF, 32'hFFFFF000, "rst_recover");

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 15) == 0);
      c   = 3'($urandom_range(0, 7));
      imm = 25'($urandom);
      e   = model(r, c, imm);
      step(r, c, imm, e, "random");
    end

    // Unused-bit independence: flip bits outside each format's fields.
    for (int i = 0; i < 40; i++) begin
      imm = 25'($urandom);
      step(1'b0, 3'b000, imm ^ 25'h0001FFF, model(1'b0, 3'b000, imm), "i_unused");
      step(1'b0, 3'b001, imm ^ 25'h003FFE0, model(1'b0, 3'b001, imm), "s_unused");
      step(1'b0, 3'b011, imm ^ 25'h000001F, model(1'b0, 3'b011, imm), "u_unused");
      step(1'b0, 3'b100, imm ^ 25'h000001F, model(1'b0, 3'b100, imm), "j_unused");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/extend.md
EXTEND -- requirements
Module: extend

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have the port `clk`, an input of 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have the port `rst`, an input of 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the port `imm_in`, an input of 25 bits: instruction bits [31:7], so imm_in[k] = instr[k+7].
REQ-005 SHALL have the port `extend_ctrl`, an input of 3 bits: immediate format select.
REQ-006 SHALL have the port `imm_out`, an output of 32 bits: the registered extended immediate.

Function
REQ-007 SHALL compute a 32-bit immediate combinationally from imm_in and extend_ctrl, then register it into imm_out on each rising clk edge.
- Latency: exactly 1 cycle.
- imm_out is updated every cycle, with no enable.
REQ-008 SHALL, when extend_ctrl=000 (I-type), produce {20{imm_in[24]}, imm_in[24:13]}.
REQ-009 SHALL, when extend_ctrl=001 (S-type), produce {20{imm_in[24]}, imm_in[24:18], imm_in[4:0]}.
REQ-010 SHALL, when extend_ctrl=010 (B-type), produce {19{imm_in[24]}, imm_in[24], imm_in[0], imm_in[23:18], imm_in[4:1], 1'b0}.
REQ-011 SHALL, when extend_ctrl=011 (U-type), produce {imm_in[24:5], 12'b0}; there is no sign extension (unsigned upper immediate).
REQ-012 SHALL, when extend_ctrl=100 (J-type), produce {11{imm_in[24]}, imm_in[24], imm_in[12:5], imm_in[13], imm_in[23:14], 1'b0}.
REQ-013 SHALL, for reserved extend_ctrl codes 101, 110 and 111, produce 32'h0000_0000.
REQ-014 SHALL always drive bit 0 of B-type and J-type results to 0, and bits [11:0] of the U-type result to 0.
REQ-015 SHALL treat bit imm_in[24] (instr[31]) as the sole sign source for the I, S, B and J formats.
REQ-016 SHALL ignore imm_in bits unused by the selected format; changing them SHALL NOT change the result.
REQ-017 SHALL produce an output free of X values for any known inputs; all 8 extend_ctrl codes are explicitly decoded.

Reset
REQ-018 SHALL load imm_out with 32'h0000_0000 on any rising clk edge where rst=1, regardless of imm_in and extend_ctrl.
REQ-019 SHALL give reset priority over the computed value; on the first edge with rst=0, imm_out takes the value computed from the inputs present at that edge.
REQ-020 SHALL NOT reset asynchronously; asserting rst between edges leaves imm_out unchanged until the next rising edge.

Verification
REQ-021 SHALL pass the I-type scenario: ctrl=000, imm_in=0x0002000 -> imm_out=0x00000001; imm_in=0x0FFFFFF -> 0x000007FF; imm_in=0x1000000 -> 0xFFFFF800 (each one cycle later).
REQ-022 SHALL pass the S/B scenario:
- ctrl=001, imm_in=b1111100_0000001111111_10101 -> 0xFFFFFF95.
- ctrl=001, imm_in=0x00000FF -> 0x0000001F.
- ctrl=010, imm_in=b1_000011_0000001111111_1111_0 -> 0xFFFFF07E.
- ctrl=010, imm_in=b0_000000_0000001111111_1111_1 -> 0x0000081E.
REQ-023 SHALL pass the U/J scenario:
- ctrl=011, imm_in=b11111111111111111111_00000 -> 0xFFFFF000.
- ctrl=100, imm_in=b0_1111111111_1_11111111_11111 -> 0x000FFFFE.
- ctrl=100, imm_in=b1_0000000000_0_00000000_11111 -> 0xFFF00000.
REQ-024 SHALL pass the reserved-code scenario: ctrl=101, 110 and 111, each with imm_in=0x1FFFFFF -> 0x00000000.
REQ-025 SHALL pass the reset scenario:
- rst=1 for 2 edges with ctrl=000, imm_in=0x1000000 -> imm_out=0.
- Deassert rst -> 0xFFFFF800 after the next edge.
- Reassert rst mid-stream -> 0 on the following edge.
REQ-026 SHALL pass the latency scenario: change the inputs between edges -> imm_out holds its old value until the next rising edge, then shows the new result.
